// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_scoreboard
// Description : Multi-port integer register file with x0 hard-wired to zero.
//               Provides NRP combinational read ports and NWP synchronous
//               write ports, where the highest-index port wins a collision.
//               A per-register busy scoreboard is set at issue and cleared
//               at writeback; flush clears every busy bit.
//               Optional macro RF_BYPASS_EN adds a same-cycle path from the
//               write ports to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRP   = 2,
  parameter int NWP   = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  localparam logic [AW:0] C_NREGS = (AW+1)'(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  // An address is backed by storage when it is neither x0 nor past the end.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < C_NREGS);
  endfunction

  // Register storage: later (higher-index) write ports override earlier ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en[w] && addr_ok(wr_addr[w*AW +: AW])) begin
          r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Busy next-state: writeback clears, issue sets over it, flush clears all.
  always_comb begin
    w_busy_next = r_busy;
    for (int r = 1; r < NREGS; r++) begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
          w_busy_next[r] = 1'b0;
        end
      end
      if (iss_valid && (iss_rd == AW'(r))) begin
        w_busy_next[r] = 1'b1;
      end
      if (flush) begin
        w_busy_next[r] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b0;
  end

  // Busy scoreboard state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Population count of the registered busy bits.
  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_cnt = busy_cnt + (AW+1)'(r_busy[r]);
    end
  end

  generate
    for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_hit;

      assign w_addr = rd_addr[p*AW +: AW];

      // Read mux, optionally overridden by a same-cycle writeback.
      always_comb begin
        w_data = '0;
        w_hit  = 1'b0;
        if (addr_ok(w_addr)) begin
          w_data = r_regs[w_addr];
        end
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWP; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == w_addr) && addr_ok(w_addr)) begin
            w_data = wr_data[w*XLEN +: XLEN];
            w_hit  = 1'b1;
          end
        end
`endif
      end

      assign rd_data[p*XLEN +: XLEN] = w_data;
      assign rd_busy[p] = addr_ok(w_addr) ? (r_busy[w_addr] & ~w_hit) : 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
